shift_register: RTL and testbench

// - Parallel-in / serial-out (PISO) shift register. Default width is 4 bits.
// - Loads a parallel word on demand, then presents one bit per clock on a serial output.
// - Used as a serializer leaf in the datapath. Driven through the standard interface bundle
//   (clk, reset, load, parallel_data_in, serial_data_out).
//

---
 rtl/shift_register.sv | 40 ++++
 tb/tb_shift_register.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Parallel-in / serial-out shift register: loads a word on demand, then presents
// one bit per clock on serial_data_out, draining with FILL_BIT afterwards.
module shift_register #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit FILL_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_data_in,
   output logic             serial_data_out
);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shifted;

   // The shift direction follows the presentation order so the next bit lands on the output end.
   always_comb begin
      sr_shifted = sr;
      if (MSB_FIRST) begin
         sr_shifted = {sr[WIDTH-2:0], FILL_BIT};
      end else begin
         sr_shifted = {FILL_BIT, sr[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= parallel_data_in;
      end else begin
         sr <= sr_shifted;
      end
   end

   assign serial_data_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: an MSB-first/fill-0 and an LSB-first/fill-1
// instance share stimulus and are checked against a queue-of-bits reference model.
module tb_shift_register;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b1;
   logic [WIDTH-1:0] parallel_data_in = 4'hF;
   logic             out_a;
   logic             out_b;

   typedef struct {
      bit    a;
      bit    b;
      string tag;
   } exp_t;

   exp_t  sb[$];
   bit    qa[$];
   bit    qb[$];
   string phase = "reset";
   int    checks = 0;
   int    failures = 0;

   shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_a (
      .clk(clk),
      .reset(reset),
      .load(load),
      .parallel_data_in(parallel_data_in),
      .serial_data_out(out_a)
   );

   shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .FILL_BIT(1'b1)) dut_b (
      .clk(clk),
      .reset(reset),
      .load(load),
      .parallel_data_in(parallel_data_in),
      .serial_data_out(out_b)
   );

   always #5 clk = ~clk;

   // Reference: each config holds the bits still to be presented, in order; an empty queue shows the fill bit.
   // A cleared register behaves like a freshly loaded all-zero word.
   task automatic push_expected();
      exp_t e;
      e.a   = (qa.size() > 0) ? qa[0] : 1'b0;
      e.b   = (qb.size() > 0) ? qb[0] : 1'b1;
      e.tag = phase;
      sb.push_back(e);
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      for (int i = 0; i < WIDTH; i++) begin
         qa.push_back(1'b0);
         qb.push_back(1'b0);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            model_clear();
         end else if (load) begin
            qa.delete();
            qb.delete();
            for (int i = WIDTH - 1; i >= 0; i--) qa.push_back(parallel_data_in[i]);
            for (int i = 0; i < WIDTH; i++) qb.push_back(parallel_data_in[i]);
         end else begin
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
         end
         push_expected();
      end
   end

   task automatic check_output(input string name, input bit actual, input bit required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s at %0t: actual=%0b required=%0b", name, $time, actual, required);
      end
   endtask

   // Monitor: one expected entry per presented state, sampled shortly after each falling clock or reset edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge reset);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output({e.tag, "/msb_fill0"}, out_a, e.a);
            check_output({e.tag, "/lsb_fill1"}, out_b, e.b);
         end
      end
   end

   task automatic apply_stimulus(input logic ld, input logic [WIDTH-1:0] d);
      @(posedge clk);
      #1;
      load = ld;
      parallel_data_in = d;
   endtask

   task automatic shift_n(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 'x);
   endtask

   task automatic set_reset(input logic value);
      @(negedge clk);
      #2;
      reset = value;
   endtask

   initial begin
      logic [WIDTH-1:0] word;
      int gap;

      repeat (3) apply_stimulus(1'b1, 4'hF);
      apply_stimulus(1'b0, 'x);
      set_reset(1'b1);
      phase = "post_reset";
      shift_n(5);

      phase = "load_1011";
      apply_stimulus(1'b1, 4'b1011);
      shift_n(6);

      phase = "back_to_back";
      apply_stimulus(1'b1, 4'hA);
      shift_n(3);
      apply_stimulus(1'b1, 4'h5);
      shift_n(5);

      phase = "abort";
      apply_stimulus(1'b1, 4'hC);
      shift_n(1);
      apply_stimulus(1'b1, 4'h3);
      shift_n(5);

      phase = "async_reset";
      apply_stimulus(1'b1, 4'hF);
      shift_n(1);
      @(posedge clk);
      set_reset(1'b0);
      set_reset(1'b1);
      shift_n(6);

      phase = "random";
      for (int w = 0; w < 200; w++) begin
         word = WIDTH'($urandom);
         gap  = int'($urandom_range(0, 6));
         apply_stimulus(1'b1, word);
         shift_n(gap);
      end
      shift_n(WIDTH + 1);

      repeat (2) @(negedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
